// File: rtl/cpcs_tx_gearbox.sv
// cpcs_tx_gearbox: TX width gearbox for the CorePCS 8b/10b encode path.
// Collects RATIO input words (data plus per-byte k/disp_sel/force_disp flags)
// into one RATIO-times-wider frame. The first word of a frame lands in the
// most-significant slot. Supports optional K28.5 idle fill on idle cycles,
// a realign pulse that restarts the frame at phase 0, and a sticky flag that
// records a realign which discarded a partially built frame.
module cpcs_tx_gearbox #(
  parameter int ENDEC_DWIDTH = 16,
  parameter int KWIDTH       = ENDEC_DWIDTH / 8,
  parameter int RATIO        = 2,
  parameter int FILL_IDLE    = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [ENDEC_DWIDTH-1:0]            d_in,
  input  logic [KWIDTH-1:0]                  k_in,
  input  logic [KWIDTH-1:0]                  disp_sel_in,
  input  logic [KWIDTH-1:0]                  force_disp_in,
  input  logic                               align,
  input  logic                               clr_err,
  output logic [ENDEC_DWIDTH*RATIO-1:0]      dout,
  output logic [KWIDTH*RATIO-1:0]            kout,
  output logic [KWIDTH*RATIO-1:0]            disp_sel_out,
  output logic [KWIDTH*RATIO-1:0]            force_disp_out,
  output logic                               out_valid,
  output logic [$clog2(RATIO)-1:0]           phase,
  output logic                               align_err
);

  localparam int DW  = ENDEC_DWIDTH;
  localparam int AW  = (RATIO - 1) * DW;      // data accumulator width
  localparam int AKW = (RATIO - 1) * KWIDTH;  // flag accumulator width
  localparam int PW  = $clog2(RATIO);

  localparam logic [PW-1:0]     PH_ZERO = PW'(0);
  localparam logic [PW-1:0]     PH_ONE  = PW'(1);
  localparam logic [PW-1:0]     PH_LAST = PW'(RATIO - 1);

  // K28.5 idle word: every byte 8'hBC, every byte flagged as a K character.
  localparam logic [DW-1:0]     IDLE_D  = {KWIDTH{8'hBC}};
  localparam logic [KWIDTH-1:0] K_ONES  = {KWIDTH{1'b1}};
  localparam logic [KWIDTH-1:0] K_ZERO  = {KWIDTH{1'b0}};

  // Partial-frame accumulators; older words sit in the upper slots.
  logic [AW-1:0]           acc_data_q, acc_data_d;
  logic [AKW-1:0]          acc_k_q,    acc_k_d;
  logic [AKW-1:0]          acc_ds_q,   acc_ds_d;
  logic [AKW-1:0]          acc_fd_q,   acc_fd_d;

  // Registered frame outputs and control state.
  logic [DW*RATIO-1:0]     dout_q;
  logic [KWIDTH*RATIO-1:0] kout_q;
  logic [KWIDTH*RATIO-1:0] ds_out_q;
  logic [KWIDTH*RATIO-1:0] fd_out_q;
  logic                    out_valid_q;
  logic [PW-1:0]           phase_q,  phase_d;
  logic                    align_err_q, align_err_d;

  // Word actually taken this cycle (real input or idle substitute).
  logic                    accept_s;
  logic                    frame_ld_s;
  logic [DW-1:0]           w_data_s;
  logic [KWIDTH-1:0]       w_k_s;
  logic [KWIDTH-1:0]       w_ds_s;
  logic [KWIDTH-1:0]       w_fd_s;

  // Accumulator contents with the current word appended at the LS end.
  logic [DW*RATIO-1:0]     shift_data_s;
  logic [KWIDTH*RATIO-1:0] shift_k_s;
  logic [KWIDTH*RATIO-1:0] shift_ds_s;
  logic [KWIDTH*RATIO-1:0] shift_fd_s;

  // A word is taken on every valid cycle, and on every cycle when idle fill is on.
  assign accept_s = in_valid | (FILL_IDLE != 0);

  // Choose between the incoming word and the K28.5 idle word.
  always_comb begin
    w_data_s = IDLE_D;
    w_k_s    = K_ONES;
    w_ds_s   = K_ZERO;
    w_fd_s   = K_ZERO;
    if (in_valid) begin
      w_data_s = d_in;
      w_k_s    = k_in;
      w_ds_s   = disp_sel_in;
      w_fd_s   = force_disp_in;
    end else begin
      w_data_s = IDLE_D;
      w_k_s    = K_ONES;
      w_ds_s   = K_ZERO;
      w_fd_s   = K_ZERO;
    end
  end

  // Each field shifts by its own width so data and flag lanes never mix.
  assign shift_data_s = {acc_data_q, w_data_s};
  assign shift_k_s    = {acc_k_q,    w_k_s};
  assign shift_ds_s   = {acc_ds_q,   w_ds_s};
  assign shift_fd_s   = {acc_fd_q,   w_fd_s};

  // Next-state logic: phase advance, frame completion, realign and error flag.
  always_comb begin
    acc_data_d  = acc_data_q;
    acc_k_d     = acc_k_q;
    acc_ds_d    = acc_ds_q;
    acc_fd_d    = acc_fd_q;
    phase_d     = phase_q;
    frame_ld_s  = 1'b0;
    align_err_d = align_err_q;

    if (align) begin
      // Restart the frame; a word arriving with the pulse becomes slot 0.
      // Stale upper slots are don't-care: they are shifted out before use.
      if (accept_s) begin
        acc_data_d = shift_data_s[AW-1:0];
        acc_k_d    = shift_k_s[AKW-1:0];
        acc_ds_d   = shift_ds_s[AKW-1:0];
        acc_fd_d   = shift_fd_s[AKW-1:0];
        phase_d    = PH_ONE;
      end else begin
        phase_d    = PH_ZERO;
      end
    end else if (accept_s) begin
      acc_data_d = shift_data_s[AW-1:0];
      acc_k_d    = shift_k_s[AKW-1:0];
      acc_ds_d   = shift_ds_s[AKW-1:0];
      acc_fd_d   = shift_fd_s[AKW-1:0];
      if (phase_q == PH_LAST) begin
        phase_d    = PH_ZERO;
        frame_ld_s = 1'b1;
      end else begin
        phase_d    = phase_q + PH_ONE;
      end
    end else begin
      phase_d = phase_q;
    end

    // Set has priority over clear when both happen in the same cycle.
    if (align && (phase_q != PH_ZERO)) begin
      align_err_d = 1'b1;
    end else if (clr_err) begin
      align_err_d = 1'b0;
    end else begin
      align_err_d = align_err_q;
    end
  end

  // State and output registers; reset leaves an idle frame on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data_q  <= {(RATIO-1){IDLE_D}};
      acc_k_q     <= {AKW{1'b1}};
      acc_ds_q    <= {AKW{1'b0}};
      acc_fd_q    <= {AKW{1'b0}};
      dout_q      <= {RATIO{IDLE_D}};
      kout_q      <= {(KWIDTH*RATIO){1'b1}};
      ds_out_q    <= {(KWIDTH*RATIO){1'b0}};
      fd_out_q    <= {(KWIDTH*RATIO){1'b0}};
      out_valid_q <= 1'b0;
      phase_q     <= PH_ZERO;
      align_err_q <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_k_q     <= acc_k_d;
      acc_ds_q    <= acc_ds_d;
      acc_fd_q    <= acc_fd_d;
      out_valid_q <= frame_ld_s;
      phase_q     <= phase_d;
      align_err_q <= align_err_d;
      if (frame_ld_s) begin
        dout_q   <= shift_data_s;
        kout_q   <= shift_k_s;
        ds_out_q <= shift_ds_s;
        fd_out_q <= shift_fd_s;
      end else begin
        dout_q   <= dout_q;
        kout_q   <= kout_q;
        ds_out_q <= ds_out_q;
        fd_out_q <= fd_out_q;
      end
    end
  end

  assign dout           = dout_q;
  assign kout           = kout_q;
  assign disp_sel_out   = ds_out_q;
  assign force_disp_out = fd_out_q;
  assign out_valid      = out_valid_q;
  assign phase          = phase_q;
  assign align_err      = align_err_q;

endmodule

// File: tb/tb_cpcs_tx_gearbox.sv
// Bench for cpcs_tx_gearbox: four instances (RATIO 2/4/3 without idle fill,
// RATIO 2 with idle fill) share one input stream. A word-list reference
// model predicts every instance's outputs; directed scenarios also compare
// against hand-written constants.
module tb_cpcs_tx_gearbox;

  localparam int ND = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, align, clr_err;
  logic [15:0] d_in;
  logic [1:0]  k_in, ds_in, fd_in;

  logic [31:0] r2_dout; logic [3:0] r2_k, r2_ds, r2_fd; logic r2_ov, r2_err; logic [0:0] r2_ph;
  logic [63:0] r4_dout; logic [7:0] r4_k, r4_ds, r4_fd; logic r4_ov, r4_err; logic [1:0] r4_ph;
  logic [47:0] r3_dout; logic [5:0] r3_k, r3_ds, r3_fd; logic r3_ov, r3_err; logic [1:0] r3_ph;
  logic [31:0] f2_dout; logic [3:0] f2_k, f2_ds, f2_fd; logic f2_ov, f2_err; logic [0:0] f2_ph;

  cpcs_tx_gearbox #(.ENDEC_DWIDTH(16), .RATIO(2), .FILL_IDLE(0)) u_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_in(d_in), .k_in(k_in),
    .disp_sel_in(ds_in), .force_disp_in(fd_in), .align(align), .clr_err(clr_err),
    .dout(r2_dout), .kout(r2_k), .disp_sel_out(r2_ds), .force_disp_out(r2_fd),
    .out_valid(r2_ov), .phase(r2_ph), .align_err(r2_err));
  cpcs_tx_gearbox #(.ENDEC_DWIDTH(16), .RATIO(4), .FILL_IDLE(0)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_in(d_in), .k_in(k_in),
    .disp_sel_in(ds_in), .force_disp_in(fd_in), .align(align), .clr_err(clr_err),
    .dout(r4_dout), .kout(r4_k), .disp_sel_out(r4_ds), .force_disp_out(r4_fd),
    .out_valid(r4_ov), .phase(r4_ph), .align_err(r4_err));
  cpcs_tx_gearbox #(.ENDEC_DWIDTH(16), .RATIO(3), .FILL_IDLE(0)) u_r3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_in(d_in), .k_in(k_in),
    .disp_sel_in(ds_in), .force_disp_in(fd_in), .align(align), .clr_err(clr_err),
    .dout(r3_dout), .kout(r3_k), .disp_sel_out(r3_ds), .force_disp_out(r3_fd),
    .out_valid(r3_ov), .phase(r3_ph), .align_err(r3_err));
  cpcs_tx_gearbox #(.ENDEC_DWIDTH(16), .RATIO(2), .FILL_IDLE(1)) u_f2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_in(d_in), .k_in(k_in),
    .disp_sel_in(ds_in), .force_disp_in(fd_in), .align(align), .clr_err(clr_err),
    .dout(f2_dout), .kout(f2_k), .disp_sel_out(f2_ds), .force_disp_out(f2_fd),
    .out_valid(f2_ov), .phase(f2_ph), .align_err(f2_err));

  // Uniform, zero-extended views of the four instances.
  logic [127:0] a_dout[ND];
  logic [15:0]  a_k[ND], a_ds[ND], a_fd[ND];
  logic [7:0]   a_ph[ND];
  logic         a_ov[ND], a_err[ND];
  assign a_dout[0] = 128'(r2_dout); assign a_dout[1] = 128'(r4_dout);
  assign a_dout[2] = 128'(r3_dout); assign a_dout[3] = 128'(f2_dout);
  assign a_k[0] = 16'(r2_k);   assign a_k[1] = 16'(r4_k);   assign a_k[2] = 16'(r3_k);   assign a_k[3] = 16'(f2_k);
  assign a_ds[0] = 16'(r2_ds); assign a_ds[1] = 16'(r4_ds); assign a_ds[2] = 16'(r3_ds); assign a_ds[3] = 16'(f2_ds);
  assign a_fd[0] = 16'(r2_fd); assign a_fd[1] = 16'(r4_fd); assign a_fd[2] = 16'(r3_fd); assign a_fd[3] = 16'(f2_fd);
  assign a_ph[0] = 8'(r2_ph);  assign a_ph[1] = 8'(r4_ph);  assign a_ph[2] = 8'(r3_ph);  assign a_ph[3] = 8'(f2_ph);
  assign a_ov[0] = r2_ov;  assign a_ov[1] = r4_ov;  assign a_ov[2] = r3_ov;  assign a_ov[3] = f2_ov;
  assign a_err[0] = r2_err; assign a_err[1] = r4_err; assign a_err[2] = r3_err; assign a_err[3] = f2_err;

  // Reference model: a list of words collected so far for the current frame.
  typedef struct packed { logic [15:0] d; logic [1:0] k; logic [1:0] ds; logic [1:0] fd; } word_t;
  int unsigned  m_ratio[ND] = '{2, 4, 3, 2};
  bit           m_fill[ND]  = '{1'b0, 1'b0, 1'b0, 1'b1};
  word_t        mw[ND][8];
  int unsigned  mn[ND];
  logic [127:0] m_dout[ND];
  logic [15:0]  m_k[ND], m_ds[ND], m_fd[ND];
  logic         m_ov[ND], m_err[ND];

  int total = 0;
  int bad   = 0;

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      mn[d] = 0; m_dout[d] = '0; m_k[d] = '0;
      for (int i = 0; i < int'(m_ratio[d]); i++) begin
        m_dout[d] = (m_dout[d] << 16) | 128'hBCBC;
        m_k[d]    = (m_k[d] << 2) | 16'h3;
      end
      m_ds[d] = '0; m_fd[d] = '0; m_ov[d] = 1'b0; m_err[d] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    word_t w;
    bit    acc;
    for (int d = 0; d < ND; d++) begin
      acc = in_valid || m_fill[d];
      w   = in_valid ? word_t'({d_in, k_in, ds_in, fd_in}) : word_t'({16'hBCBC, 2'b11, 2'b00, 2'b00});
      m_ov[d] = 1'b0;
      if (align && mn[d] != 0) m_err[d] = 1'b1;
      else if (clr_err)        m_err[d] = 1'b0;
      if (align) mn[d] = 0;
      if (acc) begin
        mw[d][mn[d]] = w;
        mn[d]++;
      end
      if (!align && mn[d] == m_ratio[d]) begin
        m_dout[d] = '0; m_k[d] = '0; m_ds[d] = '0; m_fd[d] = '0;
        for (int i = 0; i < int'(mn[d]); i++) begin
          m_dout[d] = (m_dout[d] << 16) | 128'(mw[d][i].d);
          m_k[d]    = (m_k[d]  << 2) | 16'(mw[d][i].k);
          m_ds[d]   = (m_ds[d] << 2) | 16'(mw[d][i].ds);
          m_fd[d]   = (m_fd[d] << 2) | 16'(mw[d][i].fd);
        end
        m_ov[d] = 1'b1;
        mn[d]   = 0;
      end
    end
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; align = 1'b0; clr_err = 1'b0;
    d_in = 16'h0000; k_in = 2'b00; ds_in = 2'b00; fd_in = 2'b00;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: inputs are driven now, sampled at the next rising edge.
  task automatic cycle(input logic iv, input logic [15:0] d, input logic [1:0] k,
                       input logic [1:0] ds, input logic [1:0] fd,
                       input logic al, input logic cl);
    in_valid = iv; d_in = d; k_in = k; ds_in = ds; fd_in = fd; align = al; clr_err = cl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (r2_dout !== 32'hBCBCBCBC) begin bad++; $display("FAIL reset_dout act=%h exp=%h", r2_dout, 32'hBCBCBCBC); end
    total++; if (r2_k !== 4'hF) begin bad++; $display("FAIL reset_kout act=%h exp=%h", r2_k, 4'hF); end
    total++; if (r2_ds !== 4'h0 || r2_fd !== 4'h0) begin bad++; $display("FAIL reset_disp act=%h/%h exp=0/0", r2_ds, r2_fd); end
    total++; if (r2_ov !== 1'b0 || r2_ph !== 1'b0 || r2_err !== 1'b0) begin bad++; $display("FAIL reset_ctrl act ov=%b ph=%0d err=%b exp 0/0/0", r2_ov, r2_ph, r2_err); end
    total++; if (r4_dout !== 64'hBCBCBCBCBCBCBCBC || r4_k !== 8'hFF) begin bad++; $display("FAIL reset_r4 act=%h/%h exp=bcbcbcbcbcbcbcbc/ff", r4_dout, r4_k); end
  endtask

  task automatic test_ratio2();
    do_reset();
    cycle(1'b1, 16'h1111, 2'b01, 2'b10, 2'b01, 1'b0, 1'b0);
    total++; if (r2_ov !== 1'b0 || r2_ph !== 1'b1) begin bad++; $display("FAIL r2_first act ov=%b ph=%0d exp ov=0 ph=1", r2_ov, r2_ph); end
    cycle(1'b1, 16'h2222, 2'b10, 2'b01, 2'b11, 1'b0, 1'b0);
    total++; if (r2_dout !== 32'h11112222) begin bad++; $display("FAIL r2_dout act=%h exp=%h", r2_dout, 32'h11112222); end
    total++; if (r2_k !== 4'b0110) begin bad++; $display("FAIL r2_kout act=%b exp=%b", r2_k, 4'b0110); end
    total++; if (r2_ds !== 4'b1001 || r2_fd !== 4'b0111) begin bad++; $display("FAIL r2_disp act=%b/%b exp=1001/0111", r2_ds, r2_fd); end
    total++; if (r2_ov !== 1'b1 || r2_ph !== 1'b0) begin bad++; $display("FAIL r2_valid act ov=%b ph=%0d exp ov=1 ph=0", r2_ov, r2_ph); end
    cycle(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    total++; if (r2_ov !== 1'b0 || r2_dout !== 32'h11112222) begin bad++; $display("FAIL r2_hold act ov=%b dout=%h exp ov=0 dout=11112222", r2_ov, r2_dout); end
  endtask

  task automatic test_gap();
    logic [15:0] w[4];
    logic [7:0]  exp_ph[5];
    logic        iv[5];
    w = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    iv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_ph = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd0};
    do_reset();
    #1;
    total++; if (r4_ph !== 2'd0) begin bad++; $display("FAIL gap_ph0 act=%0d exp=0", r4_ph); end
    for (int i = 0, j = 0; i < 5; i++) begin
      cycle(iv[i], iv[i] ? w[j] : 16'hDEAD, 2'(j), 2'b00, 2'b00, 1'b0, 1'b0);
      if (iv[i]) j++;
      total++;
      if (8'(r4_ph) !== exp_ph[i] || r4_ov !== (i == 4)) begin
        bad++; $display("FAIL gap_step%0d act ph=%0d ov=%b exp ph=%0d ov=%b", i, r4_ph, r4_ov, exp_ph[i], (i == 4));
      end
    end
    total++; if (r4_dout !== 64'hA001A002A003A004 || r4_k !== 8'b00011011) begin bad++; $display("FAIL gap_frame act=%h/%b exp=a001a002a003a004/00011011", r4_dout, r4_k); end
  endtask

  task automatic test_align();
    do_reset();
    cycle(1'b1, 16'h5501, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 16'h5502, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 16'hB001, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    total++; if (r4_err !== 1'b1 || r4_ph !== 2'd1 || r4_ov !== 1'b0) begin bad++; $display("FAIL align_hit act err=%b ph=%0d ov=%b exp 1/1/0", r4_err, r4_ph, r4_ov); end
    for (int i = 2; i <= 4; i++) begin
      cycle(1'b1, 16'hB000 + 16'(i), 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      total++; if (r4_ov !== (i == 4)) begin bad++; $display("FAIL align_ov%0d act=%b exp=%b", i, r4_ov, (i == 4)); end
    end
    total++; if (r4_dout !== 64'hB001B002B003B004 || r4_k !== 8'b01000000) begin bad++; $display("FAIL align_frame act=%h/%b exp=b001b002b003b004/01000000", r4_dout, r4_k); end
    cycle(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    total++; if (r4_err !== 1'b0) begin bad++; $display("FAIL align_clr act=%b exp=0", r4_err); end
    cycle(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    total++; if (r4_err !== 1'b0 || r4_ph !== 2'd0) begin bad++; $display("FAIL align_ph0 act err=%b ph=%0d exp 0/0", r4_err, r4_ph); end
    cycle(1'b1, 16'h7777, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    total++; if (r4_err !== 1'b1 || r4_ph !== 2'd0) begin bad++; $display("FAIL align_setwins act err=%b ph=%0d exp 1/0", r4_err, r4_ph); end
  endtask

  task automatic test_fill();
    do_reset();
    cycle(1'b1, 16'h1234, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 16'h5678, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
    total++; if (f2_dout !== 32'h12345678 || f2_ov !== 1'b1) begin bad++; $display("FAIL fill_real act=%h ov=%b exp=12345678 ov=1", f2_dout, f2_ov); end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      total++; if (f2_ov !== (i % 2 == 1)) begin bad++; $display("FAIL fill_ov%0d act=%b exp=%b", i, f2_ov, (i % 2 == 1)); end
      if (i == 1) begin
        total++;
        if (f2_dout !== 32'hBCBCBCBC || f2_k !== 4'hF || f2_ds !== 4'h0 || f2_fd !== 4'h0) begin
          bad++; $display("FAIL fill_idle act=%h/%h/%h/%h exp=bcbcbcbc/f/0/0", f2_dout, f2_k, f2_ds, f2_fd);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 16'h3001, 2'b11, 2'b01, 2'b10, 1'b0, 1'b0);
    cycle(1'b1, 16'h3002, 2'b11, 2'b01, 2'b10, 1'b0, 1'b0);
    cycle(1'b1, 16'h3003, 2'b11, 2'b01, 2'b10, 1'b0, 1'b0);
    cycle(1'b1, 16'h3004, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    total++; if (r3_ph !== 2'd1 || r3_dout !== 48'h300130023003) begin bad++; $display("FAIL mid_pre act ph=%0d dout=%h exp 1/300130023003", r3_ph, r3_dout); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (r3_dout !== 48'hBCBCBCBCBCBC || r3_k !== 6'h3F || r3_ds !== 6'h0 || r3_fd !== 6'h0 || r3_ph !== 2'd0 || r3_ov !== 1'b0) begin
      bad++; $display("FAIL mid_async act=%h/%h/%h/%h ph=%0d ov=%b exp=bcbcbcbcbcbc/3f/0/0 ph=0 ov=0", r3_dout, r3_k, r3_ds, r3_fd, r3_ph, r3_ov);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'hC001, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 16'hC002, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 16'hC003, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    total++; if (r3_ov !== 1'b1 || r3_dout !== 48'hC001C002C003 || r3_k !== 6'b010010) begin bad++; $display("FAIL mid_frame act ov=%b %h/%b exp ov=1 c001c002c003/010010", r3_ov, r3_dout, r3_k); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 9) < 7, 16'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (a_dout[d] !== m_dout[d] || a_k[d] !== m_k[d] || a_ds[d] !== m_ds[d] || a_fd[d] !== m_fd[d] ||
            a_ov[d] !== m_ov[d] || a_ph[d] !== 8'(mn[d]) || a_err[d] !== m_err[d]) begin
          bad++;
          $display("FAIL rand_dut%0d cyc=%0d act dout=%h k=%h ds=%h fd=%h ov=%b ph=%0d err=%b exp dout=%h k=%h ds=%h fd=%h ov=%b ph=%0d err=%b",
                   d, c, a_dout[d], a_k[d], a_ds[d], a_fd[d], a_ov[d], a_ph[d], a_err[d],
                   m_dout[d], m_k[d], m_ds[d], m_fd[d], m_ov[d], mn[d], m_err[d]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_ratio2();
    test_gap();
    test_align();
    test_fill();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpcs_tx_gearbox.md
Name: cpcs_tx_gearbox

Overview:
Parametrised TX-side width gearbox for the CorePCS 8b/10b encode path. It collects RATIO consecutive ENDEC_DWIDTH-wide words, with their per-byte k, disp_sel and force_disp flags, into one RATIO-times-wider frame for the encoder/SERDES interface. Over a 2:1 double-buffer it adds:
- configurable ratio;
- input-valid qualification;
- an output-valid strobe;
- word-phase realignment;
- optional K28.5 idle insertion;
- a sticky misalignment flag.

Parameters:
ENDEC_DWIDTH, 16, input data width in bits; multiple of 8, range 8..32.
KWIDTH, ENDEC_DWIDTH/8, flag bits per input word (one per byte).
RATIO, 2, input words per output frame; range 2..8.
FILL_IDLE, 0, 1 = substitute an idle word (K28.5) on cycles where in_valid=0.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word qualifier.
- d_in  input  ENDEC_DWIDTH  input data word.
- k_in  input  KWIDTH  per-byte K-character flags.
- disp_sel_in  input  KWIDTH  per-byte disparity select.
- force_disp_in  input  KWIDTH  per-byte force disparity.
- align  input  1  synchronous realign pulse: restart frame at phase 0.
- clr_err  input  1  clears align_err.
- dout  output  ENDEC_DWIDTH*RATIO  assembled data frame.
- kout  output  KWIDTH*RATIO  assembled k flags.
- disp_sel_out  output  KWIDTH*RATIO  assembled disparity select.
- force_disp_out  output  KWIDTH*RATIO  assembled force disparity.
- out_valid  output  1  one-cycle strobe: new frame on outputs.
- phase  output  clog2(RATIO)  index of the next input slot.
- align_err  output  1  sticky: realign hit a partial frame.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low. There is no synchronous-reset option.
- Reset values:
  - dout and the internal data accumulator = every byte 8'hBC.
  - kout and the k accumulator = all 1.
  - disp_sel_out, force_disp_out and their accumulators = 0.
  - out_valid = 0, phase = 0, align_err = 0.
- Word acceptance:
  - A word is accepted when in_valid=1.
  - When FILL_IDLE=1 and in_valid=0, an idle word is accepted instead: data = each byte 8'hBC, k = all 1, disp_sel = 0, force_disp = 0.
  - When FILL_IDLE=0 and in_valid=0, the cycle is ignored: no state change except align/clr_err handling.
- Accumulation:
  - Each accepted word shifts into the LSB end of a (RATIO-1)-word accumulator; older words move up.
  - Each field shifts by its own width (ENDEC_DWIDTH or KWIDTH); fields never cross.
  - The first word of a frame ends in the MS slot; the last word is in the LS slot.
- Frame completion:
  - On an accepted word with phase=RATIO-1, on the same edge:
    - dout etc. load {accumulator, current word};
    - out_valid=1 for the following cycle;
    - phase wraps to 0.
  - Otherwise an accepted word increments phase.
  - Latency: out_valid and the frame appear on the cycle after the edge that accepted the RATIO-th word.
  - Outputs hold between frames; out_valid=0 on every other cycle.
- align=1:
  - phase is forced to 0 and partial accumulator contents are discarded. Accumulator slots are don't-care and are overwritten before use.
  - If phase≠0 when align is sampled, align_err sets. No error is flagged when phase=0.
  - align together with an accepted word: the word becomes slot 0 of the new frame, so phase=1 next. This holds for RATIO>1. No frame is emitted that cycle, even if the old phase was RATIO-1.
- align_err: sticky until clr_err=1. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- No backpressure: the sink must accept every out_valid frame.

Test Plan:
- Reset, RATIO=2, DWIDTH=16: release reset -> dout=32'hBCBCBCBC, kout=4'hF, disp_sel_out=0, out_valid=0, phase=0.
- RATIO=2: in_valid words 16'h1111 (k=2'b01), then 16'h2222 (k=2'b10) -> next cycle dout=32'h11112222, kout=4'b0110, out_valid high exactly one cycle.
- RATIO=4, FILL_IDLE=0: words A1,A2 with an in_valid=0 gap between them, then A3,A4 -> one frame {A1,A2,A3,A4}; phase sequence 0,1,1,2,3,0.
- RATIO=4: send 2 words, then align=1 with in_valid=1 on word B1, then B2..B4 -> align_err=1, frame {B1,B2,B3,B4}, no frame containing the first two words. clr_err -> align_err=0.
- FILL_IDLE=1, RATIO=2: in_valid held 0 -> out_valid every 2nd cycle, dout=32'hBCBCBCBC, kout=4'hF.
- Assert rst_n low at phase=1 of RATIO=3, then release -> all outputs at reset values; the next 3 words form a clean frame.
